lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Memory-side execution unit for decoded RV64 load/store operations. Accepts one decoded access (one-hot op flags, rd, rs1/rs2 operand values, 12-bit immediate), computes the effective address, and drives a req/gnt + rvalid data-memory handshake. For loads, it extracts and sign/zero-extends the addressed lane and returns a register writeback. Sits between the load/store decode stage and the data memory / register-file write port.

Parameters:
ADDR_W, 32, width of mem_addr; the 64-bit effective address is truncated to this width.
TMO_CYC, 255, maximum number of WAIT cycles for mem_rvalid before a timeout error (range 1..255).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
valid  in  1  decoded access present
ready  out  1  unit idle, able to accept an access
op  in  11  one-hot {sw,sh,sb,sd,ld,lwu,lhu,lbu,lw,lh,lb} (bit0=lb … bit10=sw)
rd  in  5  load destination register
rs1_val  in  64  base register value
rs2_val  in  64  store data register value
imm  in  12  signed offset
mem_req  out  1  memory request
mem_we  out  1  1=store, 0=load
mem_addr  out  ADDR_W  doubleword-aligned address (bits[2:0]=0)
mem_wdata  out  64  store data, lane-replicated
mem_wstrb  out  8  byte enables (0 for loads)
mem_gnt  in  1  request accepted
mem_rvalid  in  1  load data valid
mem_rdata  in  64  load data, full doubleword
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  5  writeback register
wb_data  out  64  writeback value
st_done  out  1  one-cycle store completion pulse
err  out  1  one-cycle error pulse
err_code  out  2  01 misaligned, 10 illegal op, 11 timeout; held until next err

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high. Reset forces state IDLE and clears every registered output to 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_valid, wb_rd, wb_data, st_done, err, err_code, and the timeout counter.
- ready = (state==IDLE), so ready reads 1 while in reset.
- Accept: valid&&ready in IDLE. Capture op, rd, rs2_val. ea = rs1_val + sign_extend64(imm), modulo 2^64. off = ea[2:0].
- Checks at accept, in priority order:
  - op not exactly one-hot -> ERR with code 10.
  - Misaligned -> ERR with code 01. Misaligned means: h-type with off[0]≠0; w-type with off[1:0]≠0; d-type with off≠0.
  - No mem_req is issued in either error case.
- States:
  - IDLE: wait for accept. Go to ERR or REQ.
  - REQ: mem_req=1, with mem_addr/mem_we/mem_wdata/mem_wstrb stable until the mem_gnt cycle.
    - On gnt with a store: go to SDONE.
    - On gnt with a load: go to WAIT and clear the counter.
    - mem_req drops in the cycle after gnt.
  - WAIT: counter increments each cycle.
    - mem_rvalid=1: register the extracted data into wb_data and rd into wb_rd; go to WB.
    - Else if counter==TMO_CYC-1: go to ERR with code 11.
    - mem_rvalid is ignored outside WAIT; the responder asserts it no earlier than the cycle after gnt.
  - WB: wb_valid=1 for one cycle; go to IDLE.
  - SDONE: st_done=1 for one cycle; go to IDLE.
  - ERR: err=1 for one cycle, err_code updated; go to IDLE.
- Latency:
  - Load with gnt in the first REQ cycle and rvalid in the first WAIT cycle: accept at T, wb_valid at T+3.
  - Store: st_done at T+2.
  - Error: err at T+1.
- Store data formation:
  - sb: wdata={8{rs2[7:0]}}, wstrb=8'h01<<off.
  - sh: wdata={4{rs2[15:0]}}, wstrb=8'h03<<off.
  - sw: wdata={2{rs2[31:0]}}, wstrb=8'h0F<<off.
  - sd: wdata=rs2, wstrb=8'hFF.
- Load extraction: s = mem_rdata >> (8*off).
  - lb/lh/lw: sign-extend s[7:0] / s[15:0] / s[31:0].
  - lbu/lhu/lwu: zero-extend s[7:0] / s[15:0] / s[31:0].
  - ld: s.
- mem_addr = {ea[ADDR_W-1:3],3'b000}. ea wrap-around is ignored (no error).
- rd=0 loads still produce wb_valid; register-file suppression is external.
- valid while not ready: ignored; the upstream stage holds its inputs.
- Reset mid-operation: immediate return to IDLE. An outstanding memory transaction is abandoned, no wb_valid/st_done/err is generated, and a late mem_rvalid is ignored.

Test Plan:
- lb, rs1=0x1000, imm=0x007, rdata=0x8877665544332211 -> mem_addr 0x1000, wstrb 0, wb_data 0xFFFFFFFFFFFFFF88; repeat as lbu -> 0x0000000000000088; wb_valid at T+3.
- sw, rs1=0x1000, imm=0x004, rs2=0x00000000DEADBEEF, gnt delayed 3 cycles -> mem_req held 3 cycles, wdata 0xDEADBEEFDEADBEEF, wstrb 0xF0, st_done one cycle after gnt.
- ld, rs1=0x1010, imm=0xFF8 (-8) -> mem_addr 0x1008, wb_data = rdata unchanged; lhu at off 6 with rdata 0xABCD000000000000 -> 0xABCD.
- lh, rs1=0x1001, imm=0 -> err=1, err_code=01, mem_req never asserted, ready back next cycle; op=0 or op=11'h003 -> err_code=10.
- TMO_CYC=4, load granted, no rvalid -> err_code=11 after 4 WAIT cycles; a later rvalid produces no wb_valid.
- rst pulse asynchronously during WAIT -> all outputs 0 immediately, ready=1 after release, a new sb accepted and completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store execution unit: effective-address generation, alignment and op
// checks, req/gnt + rvalid memory handshake, store lane formation, load extraction.
module lsu_mem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  output logic              ready,
  input  logic [10:0]       op,
  input  logic [4:0]        rd,
  input  logic [63:0]       rs1_val,
  input  logic [63:0]       rs2_val,
  input  logic [11:0]       imm,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [63:0]       wb_data,
  output logic              st_done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [2:0]        dbg_state
);

  // Handshakes: an access is taken when valid && ready (ready == IDLE); a memory
  // request holds all mem_* fields until the cycle mem_gnt is high, and load data
  // is taken only in WAIT on the first cycle mem_rvalid is high.
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WB, S_SDONE, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [5:0]          ld_q, ld_d;
  logic [2:0]          off_q, off_d;
  logic [4:0]          rd_q, rd_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [7:0]          wstrb_q, wstrb_d;
  logic                wb_valid_q, wb_valid_d;
  logic [4:0]          wb_rd_q, wb_rd_d;
  logic [63:0]         wb_data_q, wb_data_d;
  logic                st_done_q, st_done_d, err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

  logic [63:0] ea, st_wdata, shifted, ld_data;
  logic [7:0]  st_wstrb;
  logic [2:0]  off;
  logic        onehot, is_h, is_w, is_d, is_st, misalign;
  logic        unused_ea;

  assign ea        = rs1_val + {{52{imm[11]}}, imm};
  assign off       = ea[2:0];
  assign unused_ea = ^ea[63:ADDR_W];
  assign onehot    = (op != 11'd0) && ((op & (op - 11'd1)) == 11'd0);
  assign is_h      = op[1] | op[4] | op[9];
  assign is_w      = op[2] | op[5] | op[10];
  assign is_d      = op[6] | op[7];
  assign is_st     = |op[10:7];
  assign misalign  = (is_h && off[0]) || (is_w && (off[1:0] != 2'd0)) || (is_d && (off != 3'd0));

  always_comb begin
    st_wdata = rs2_val;
    st_wstrb = 8'hFF;
    if (op[8]) begin
      st_wdata = {8{rs2_val[7:0]}};
      st_wstrb = 8'h01 << off;
    end else if (op[9]) begin
      st_wdata = {4{rs2_val[15:0]}};
      st_wstrb = 8'h03 << off;
    end else if (op[10]) begin
      st_wdata = {2{rs2_val[31:0]}};
      st_wstrb = 8'h0F << off;
    end
  end

  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_data = shifted;
    if (ld_q[0])      ld_data = {{56{shifted[7]}}, shifted[7:0]};
    else if (ld_q[1]) ld_data = {{48{shifted[15]}}, shifted[15:0]};
    else if (ld_q[2]) ld_data = {{32{shifted[31]}}, shifted[31:0]};
    else if (ld_q[3]) ld_data = {56'd0, shifted[7:0]};
    else if (ld_q[4]) ld_data = {48'd0, shifted[15:0]};
    else if (ld_q[5]) ld_data = {32'd0, shifted[31:0]};
  end

  always_comb begin
    state_d    = state_q;
    ld_d       = ld_q;
    off_d      = off_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    st_done_d  = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE: if (valid) begin
        ld_d  = op[5:0];
        rd_d  = rd;
        off_d = off;
        if (!onehot) begin
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = 2'b10;
        end else if (misalign) begin
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = 2'b01;
        end else begin
          state_d = S_REQ;
          req_d   = 1'b1;
          we_d    = is_st;
          addr_d  = {ea[ADDR_W-1:3], 3'b000};
          wdata_d = st_wdata;
          wstrb_d = is_st ? st_wstrb : 8'h00;
        end
      end
      S_REQ: if (mem_gnt) begin
        req_d = 1'b0;
        if (we_q) begin
          state_d   = S_SDONE;
          st_done_d = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid) begin
          state_d    = S_WB;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = ld_data;
        end else if (cnt_q == 8'(TMO_CYC - 1)) begin
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = 2'b11;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ld_q       <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      st_done_q  <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_q       <= ld_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      st_done_q  <= st_done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign st_done   = st_done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed accesses, a byte-level outcome model with an
// expected queue, and a per-cycle compare process against the DUT outputs.
module tb_lsu_mem_ctrl;

  localparam logic [1:0] K_WB = 2'd0, K_ST = 2'd1, K_ERR = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic        mem;
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [1:0]  code;
  } exp_t;

  logic        clk, rst, valid, ready;
  logic [10:0] op;
  logic [4:0]  rd;
  logic [63:0] rs1_val, rs2_val;
  logic [11:0] imm;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;
  logic        wb_valid, st_done, err;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [1:0]  err_code;
  logic [2:0]  dbg_state;

  exp_t exp_q[$];
  int   n_chk = 0, n_err = 0, cyc = 0, acc_cyc = 0;
  int   req_len = 0, last_req_len = 0;
  int   last_wb_cyc = -1, last_st_cyc = -1, last_err_cyc = -1;
  logic [63:0] last_wb_data = '0, last_req_wdata = '0;
  logic [31:0] last_req_addr = '0;
  logic [7:0]  last_req_wstrb = '0;

  lsu_mem_ctrl #(.ADDR_W(32), .TMO_CYC(4)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .op(op), .rd(rd),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .st_done(st_done),
    .err(err), .err_code(err_code), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Outcome of one access worked out byte by byte from the ISA rules.
  function automatic exp_t model(input logic [10:0] op_v, input logic [4:0] rd_v,
                                 input logic [63:0] rs1_v, input logic [63:0] rs2_v,
                                 input logic [11:0] imm_v, input logic [63:0] rdat,
                                 input logic no_resp);
    exp_t e;
    logic [63:0] ea;
    int sizes[11] = '{1, 2, 4, 1, 2, 4, 8, 8, 1, 2, 4};
    int idx, sz, off, m;
    logic sgn;
    e = '0;
    ea = rs1_v + {{52{imm_v[11]}}, imm_v};
    e.addr = {ea[31:3], 3'b000};
    e.rd = rd_v;
    e.kind = K_ERR;
    if ($countones(op_v) != 1) begin
      e.code = 2'b10;
      return e;
    end
    idx = 0;
    for (int k = 0; k < 11; k++) if (op_v[k]) idx = k;
    sz  = sizes[idx];
    off = int'(ea[2:0]);
    sgn = (idx <= 2);
    if ((ea % 64'(sz)) != 64'd0) begin
      e.code = 2'b01;
      return e;
    end
    e.mem = 1'b1;
    e.we  = (idx >= 7);
    if (e.we) begin
      for (int b = 0; b < 8; b++) e.wdata[8*b +: 8] = rs2_v[8*(b % sz) +: 8];
      m = ((1 << sz) - 1) << off;
      e.wstrb = m[7:0];
      e.kind = K_ST;
    end else if (no_resp) begin
      e.code = 2'b11;
    end else begin
      for (int b = 0; b < 8; b++)
        if (b < sz) e.data[8*b +: 8] = rdat[8*(off+b) +: 8];
        else e.data[8*b +: 8] = (sgn && rdat[8*(off+sz)-1]) ? 8'hFF : 8'h00;
      e.kind = K_WB;
    end
    return e;
  endfunction

  // scoreboard: the unit is busy exactly while an outcome is outstanding
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      chk("rst_outputs_zero", {52'd0, mem_req, mem_we, |mem_addr, |mem_wdata, |mem_wstrb,
          wb_valid, |wb_rd, |wb_data, st_done, err, |err_code, ~ready}, 64'd0);
    end else begin
      chk("ready", ready, exp_q.size() == 0);
      if (mem_req) begin
        req_len++;
        last_req_addr = mem_addr;
        last_req_wdata = mem_wdata;
        last_req_wstrb = mem_wstrb;
        if (exp_q.size() == 0 || !exp_q[0].mem) chk("req_unexpected", 1, 0);
        else begin
          chk("mem_addr", mem_addr, exp_q[0].addr);
          chk("mem_we", mem_we, exp_q[0].we);
          chk("mem_wstrb", mem_wstrb, exp_q[0].wstrb);
          if (exp_q[0].we) chk("mem_wdata", mem_wdata, exp_q[0].wdata);
        end
      end else if (req_len != 0) begin
        last_req_len = req_len;
        req_len = 0;
      end
      if (wb_valid) begin
        last_wb_cyc = cyc;
        last_wb_data = wb_data;
        if (exp_q.size() == 0) chk("wb_spurious", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("wb_kind", K_WB, e.kind);
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_data", wb_data, e.data);
        end
      end
      if (st_done) begin
        last_st_cyc = cyc;
        if (exp_q.size() == 0) chk("st_spurious", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("st_kind", K_ST, e.kind);
        end
      end
      if (err) begin
        last_err_cyc = cyc;
        if (exp_q.size() == 0) chk("err_spurious", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("err_kind", K_ERR, e.kind);
          chk("err_code", err_code, e.code);
        end
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [10:0] o, input logic [4:0] r, input logic [63:0] a,
                       input logic [63:0] b, input logic [11:0] i, input logic [63:0] rdat,
                       input logic no_resp);
    @(posedge clk); #1;
    valid = 1'b1; op = o; rd = r; rs1_val = a; rs2_val = b; imm = i;
    acc_cyc = cyc;
    @(posedge clk); #1;
    valid = 1'b0;
    exp_q.push_back(model(o, r, a, b, i, rdat, no_resp));
  endtask

  task automatic mem_grant(input int n);
    for (int g = 1; g <= n; g++) begin
      mem_gnt = (g == n);
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0;
  endtask

  task automatic mem_return(input int n, input logic [63:0] rdat);
    for (int k = 1; k <= n; k++) begin
      mem_rvalid = (k == n);
      mem_rdata = rdat;
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (ready && exp_q.size() == 0) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("idle_within_budget", done, 1'b1);
  endtask

  task automatic run_ld(input logic [10:0] o, input logic [4:0] r, input logic [63:0] a,
                        input logic [11:0] i, input logic [63:0] rdat, input int rv);
    issue(o, r, a, 64'd0, i, rdat, 1'b0);
    mem_grant(1);
    mem_return(rv, rdat);
    wait_idle();
  endtask

  task automatic run_st(input logic [10:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [11:0] i, input int g);
    issue(o, 5'd0, a, b, i, 64'd0, 1'b0);
    mem_grant(g);
    wait_idle();
  endtask

  task automatic run_err(input logic [10:0] o, input logic [63:0] a, input logic [11:0] i);
    issue(o, 5'd3, a, 64'd0, i, 64'd0, 1'b0);
    wait_idle();
  endtask

  localparam logic [10:0] LB = 11'h001, LH = 11'h002, LW = 11'h004, LBU = 11'h008,
                          LHU = 11'h010, LWU = 11'h020, LD = 11'h040, SD = 11'h080,
                          SB = 11'h100, SH = 11'h200, SW = 11'h400;

  initial begin
    int saved;
    rst = 1'b1; valid = 1'b0; op = '0; rd = '0; rs1_val = '0; rs2_val = '0; imm = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", ready, 1'b1);
    chk("reset_err_code", err_code, 2'b00);
    rst = 1'b0;

    run_ld(LB, 5'd7, 64'h1000, 12'h007, 64'h8877665544332211, 1);
    chk("lb_data", last_wb_data, 64'hFFFFFFFFFFFFFF88);
    chk("lb_addr", last_req_addr, 32'h1000);
    chk("lb_wstrb", last_req_wstrb, 8'h00);
    chk("lb_latency", last_wb_cyc - acc_cyc, 3);
    run_ld(LBU, 5'd8, 64'h1000, 12'h007, 64'h8877665544332211, 1);
    chk("lbu_data", last_wb_data, 64'h88);
    chk("lbu_latency", last_wb_cyc - acc_cyc, 3);

    run_st(SW, 64'h1000, 64'h00000000DEADBEEF, 12'h004, 3);
    chk("sw_req_len", last_req_len, 3);
    chk("sw_wdata", last_req_wdata, 64'hDEADBEEFDEADBEEF);
    chk("sw_wstrb", last_req_wstrb, 8'hF0);
    chk("sw_st_latency", last_st_cyc - acc_cyc, 4);

    run_ld(LD, 5'd9, 64'h1010, 12'hFF8, 64'h0123456789ABCDEF, 1);
    chk("ld_addr", last_req_addr, 32'h1008);
    chk("ld_data", last_wb_data, 64'h0123456789ABCDEF);
    run_ld(LHU, 5'd10, 64'h1006, 12'h000, 64'hABCD000000000000, 1);
    chk("lhu_data", last_wb_data, 64'hABCD);
    run_ld(LH, 5'd11, 64'h1006, 12'h000, 64'hABCD000000000000, 2);
    run_ld(LW, 5'd12, 64'h2004, 12'h000, 64'h8000000000000000, 3);
    chk("lw_sign", last_wb_data, 64'hFFFFFFFF80000000);
    run_ld(LWU, 5'd13, 64'h2004, 12'h000, 64'h8000000000000000, 1);
    run_ld(LW, 5'd0, 64'hFFFFFFFFFFFFFFFC, 12'h008, 64'h1122334455667788, 1);
    chk("wrap_addr", last_req_addr, 32'h0);
    run_st(SH, 64'h3002, 64'h1234, 12'h000, 1);
    chk("sh_wstrb", last_req_wstrb, 8'h0C);
    run_st(SB, 64'h3000, 64'hA5, 12'h005, 2);
    run_st(SD, 64'h3008, 64'hCAFEF00D12345678, 12'h000, 1);
    chk("sd_st_latency", last_st_cyc - acc_cyc, 2);

    run_err(LH, 64'h1001, 12'h000);
    chk("mis_latency", last_err_cyc - acc_cyc, 1);
    chk("mis_code_held", err_code, 2'b01);
    run_err(11'h000, 64'h1000, 12'h000);
    chk("op0_code_held", err_code, 2'b10);
    run_err(11'h003, 64'h1001, 12'h000);
    run_err(SD, 64'h1004, 12'h000);
    run_err(SW, 64'h1002, 12'h000);

    issue(LW, 5'd4, 64'h4000, 64'd0, 12'h000, 64'd0, 1'b1);
    mem_grant(1);
    wait_idle();
    chk("tmo_latency", last_err_cyc - acc_cyc, 6);
    chk("tmo_code", err_code, 2'b11);
    saved = last_wb_cyc;
    mem_return(1, 64'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    chk("late_rvalid_ignored", last_wb_cyc, saved);

    issue(LD, 5'd5, 64'h5000, 64'd0, 12'h000, 64'd0, 1'b1);
    mem_grant(1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {52'd0, mem_req, mem_we, |mem_addr, |mem_wdata, |mem_wstrb,
        wb_valid, |wb_rd, |wb_data, st_done, err, |err_code, ~ready}, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    saved = last_wb_cyc;
    mem_return(1, 64'h1234);
    chk("rst_abandon_no_wb", last_wb_cyc, saved);
    run_st(SB, 64'h6000, 64'h5A, 12'h003, 1);
    chk("post_rst_sb", last_st_cyc - acc_cyc, 2);
    chk("post_rst_sb_wstrb", last_req_wstrb, 8'h08);

    repeat (2) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
